// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with exact occupancy, programmable almost-full/almost-empty
// thresholds, standard or first-word-fall-through read, and sticky error flags.
module sync_fifo_prog #(
    parameter int  DATA_WIDTH = 32,
    parameter int  DEPTH      = 256,
    parameter bit  FWFT       = 1'b0,
    localparam int AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en_i,
    input  logic [DATA_WIDTH-1:0] data_in_i,
    input  logic                  rd_en_i,
    input  logic [AW:0]           af_thresh_i,
    input  logic [AW:0]           ae_thresh_i,
    input  logic                  clr_err_i,
    output logic [DATA_WIDTH-1:0] data_out_o,
    output logic                  valid_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic                  almost_full_o,
    output logic                  almost_empty_o,
    output logic [AW:0]           count_o,
    output logic                  overflow_o,
    output logic                  underflow_o
);

    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [AW:0]           count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  wr_acc, rd_acc;

    assign full_o         = (count_q == FULL_CNT);
    assign empty_o        = (count_q == '0);
    assign almost_full_o  = (count_q >= af_thresh_i);
    assign almost_empty_o = (count_q <= ae_thresh_i);
    assign count_o        = count_q;
    assign overflow_o     = overflow_q;
    assign underflow_o    = underflow_q;

    assign wr_acc = wr_en_i && !full_o;
    assign rd_acc = rd_en_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_acc ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = rd_acc ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        count_d  = count_q;
        if (wr_acc && !rd_acc) begin
            count_d = count_q + CNT_ONE;
        end else if (rd_acc && !wr_acc) begin
            count_d = count_q - CNT_ONE;
        end
        // A fresh error in the same cycle as clr_err keeps the flag set.
        overflow_d  = (wr_en_i && full_o)  || (overflow_q  && !clr_err_i);
        underflow_d = (rd_en_i && empty_o) || (underflow_q && !clr_err_i);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr_q] <= data_in_i;
        end
    end

    if (FWFT) begin : g_fwft
        assign data_out_o = mem[rd_ptr_q];
        assign valid_o    = !empty_o;
    end else begin : g_std
        logic [DATA_WIDTH-1:0] data_q;
        logic                  valid_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                data_q  <= '0;
                valid_q <= 1'b0;
            end else begin
                valid_q <= rd_acc;
                if (rd_acc) begin
                    data_q <= mem[rd_ptr_q];
                end
            end
        end

        assign data_out_o = data_q;
        assign valid_o    = valid_q;
    end

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Bench for sync_fifo_prog: one standard-mode and one FWFT instance (DEPTH=8),
// checked every cycle against a queue model plus directed literal expectations.
module tb_sync_fifo_prog;

    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int CW    = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [1:0]         w = '0, r = '0, clr = '0;
    logic [1:0][DW-1:0] din = '0;
    logic [1:0][CW-1:0] af = '0, ae = '0;

    logic [1:0][DW-1:0] dout;
    logic [1:0][CW-1:0] cnt;
    logic [1:0]         vld, full, empty, afl, ael, ov, un;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sync_fifo_prog #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(1'b0)) u_std (
        .clk(clk), .rst(rst),
        .wr_en_i(w[0]), .data_in_i(din[0]), .rd_en_i(r[0]),
        .af_thresh_i(af[0]), .ae_thresh_i(ae[0]), .clr_err_i(clr[0]),
        .data_out_o(dout[0]), .valid_o(vld[0]), .full_o(full[0]), .empty_o(empty[0]),
        .almost_full_o(afl[0]), .almost_empty_o(ael[0]), .count_o(cnt[0]),
        .overflow_o(ov[0]), .underflow_o(un[0])
    );

    sync_fifo_prog #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(1'b1)) u_fwft (
        .clk(clk), .rst(rst),
        .wr_en_i(w[1]), .data_in_i(din[1]), .rd_en_i(r[1]),
        .af_thresh_i(af[1]), .ae_thresh_i(ae[1]), .clr_err_i(clr[1]),
        .data_out_o(dout[1]), .valid_o(vld[1]), .full_o(full[1]), .empty_o(empty[1]),
        .almost_full_o(afl[1]), .almost_empty_o(ael[1]), .count_o(cnt[1]),
        .overflow_o(ov[1]), .underflow_o(un[1])
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Queue model: occupancy is just the queue length.
    logic [DW-1:0] mq [2][$];
    bit   [1:0]    m_ov = '0, m_un = '0, m_vld = '0;
    logic [1:0][DW-1:0] m_dout = '0;

    always @(posedge clk or posedge rst) begin
        for (int u = 0; u < 2; u++) begin
            if (rst) begin
                mq[u].delete();
                m_ov[u]   = 1'b0;
                m_un[u]   = 1'b0;
                m_vld[u]  = 1'b0;
                m_dout[u] = '0;
            end else begin
                int  sz;
                bit  do_wr, do_rd;
                sz      = mq[u].size();
                do_wr   = w[u] && (sz < DEPTH);
                do_rd   = r[u] && (sz > 0);
                m_ov[u] = (w[u] && sz == DEPTH) || (m_ov[u] && !clr[u]);
                m_un[u] = (r[u] && sz == 0) || (m_un[u] && !clr[u]);
                m_vld[u] = do_rd;
                if (do_rd) m_dout[u] = mq[u].pop_front();
                if (do_wr) mq[u].push_back(din[u]);
            end
        end
    end

    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            int sz;
            sz = mq[u].size();
            chk($sformatf("count%0d", u), 32'(cnt[u]), 32'(sz));
            chk($sformatf("full%0d", u), 32'(full[u]), 32'(sz == DEPTH));
            chk($sformatf("empty%0d", u), 32'(empty[u]), 32'(sz == 0));
            chk($sformatf("almost_full%0d", u), 32'(afl[u]), 32'(sz >= int'(af[u])));
            chk($sformatf("almost_empty%0d", u), 32'(ael[u]), 32'(sz <= int'(ae[u])));
            chk($sformatf("overflow%0d", u), 32'(ov[u]), 32'(m_ov[u]));
            chk($sformatf("underflow%0d", u), 32'(un[u]), 32'(m_un[u]));
            if (u == 0) begin
                chk("valid0", 32'(vld[0]), 32'(m_vld[0]));
                chk("data_out0", 32'(dout[0]), 32'(m_dout[0]));
            end else begin
                chk("valid1", 32'(vld[1]), 32'(sz != 0));
                if (sz != 0) chk("data_out1", 32'(dout[1]), 32'(mq[1][0]));
            end
        end
    end

    initial begin
        af[0] = 4'd6; ae[0] = 4'd2;
        af[1] = 4'd8; ae[1] = 4'd0;
        #1;
        chk("rst_count", 32'(cnt[0]), 32'd0);
        chk("rst_empty", 32'(empty[0]), 32'd1);
        chk("rst_valid", 32'(vld[0]), 32'd0);
        step(); step();
        rst = 1'b0;

        // Fill to full, then one write too many.
        w[0] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            din[0] = DW'(8'h10 + i);
            step();
        end
        chk("fill_count", 32'(cnt[0]), 32'd8);
        chk("fill_full", 32'(full[0]), 32'd1);
        din[0] = 8'h99;
        step();
        w[0] = 1'b0;
        chk("ovf_set", 32'(ov[0]), 32'd1);
        chk("ovf_count", 32'(cnt[0]), 32'd8);

        r[0] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("drain_data", 32'(dout[0]), 32'(8'h10 + i));
            chk("drain_valid", 32'(vld[0]), 32'd1);
        end
        r[0] = 1'b0;
        step();
        chk("drain_valid_off", 32'(vld[0]), 32'd0);
        chk("drain_empty", 32'(empty[0]), 32'd1);
        clr[0] = 1'b1; step(); clr[0] = 1'b0;
        chk("ovf_clr", 32'(ov[0]), 32'd0);

        // Underflow and clear priority.
        r[0] = 1'b1; step(); r[0] = 1'b0;
        chk("unf_set", 32'(un[0]), 32'd1);
        chk("unf_valid", 32'(vld[0]), 32'd0);
        clr[0] = 1'b1; step(); clr[0] = 1'b0;
        chk("unf_clr", 32'(un[0]), 32'd0);
        clr[0] = 1'b1; r[0] = 1'b1; step(); clr[0] = 1'b0; r[0] = 1'b0;
        chk("unf_clr_race", 32'(un[0]), 32'd1);
        clr[0] = 1'b1; step(); clr[0] = 1'b0;

        // Threshold flags while filling one word at a time.
        w[0] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            din[0] = DW'(8'h20 + i);
            step();
            chk("ae_fill", 32'(ael[0]), 32'(i + 1 <= 2));
            chk("af_fill", 32'(afl[0]), 32'(i + 1 >= 6));
        end
        w[0] = 1'b0;
        af[0] = 4'd7;
        #1;
        chk("af_thresh_move", 32'(afl[0]), 32'd0);
        w[0] = 1'b1;
        din[0] = 8'h26; step();
        din[0] = 8'h27; step();
        w[0] = 1'b0;

        // Simultaneous read/write while full.
        w[0] = 1'b1; r[0] = 1'b1; din[0] = 8'h30;
        step();
        w[0] = 1'b0; r[0] = 1'b0;
        chk("full_rw_count", 32'(cnt[0]), 32'd7);
        chk("full_rw_ovf", 32'(ov[0]), 32'd1);
        chk("full_rw_data", 32'(dout[0]), 32'h20);
        r[0] = 1'b1; step(); step(); step(); r[0] = 1'b0;

        // Steady read/write at count 4 across pointer wrap.
        w[0] = 1'b1; r[0] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            din[0] = DW'(8'h40 + i);
            step();
            chk("rw_count", 32'(cnt[0]), 32'd4);
            chk("rw_data", 32'(dout[0]), (i < 4) ? 32'(8'h24 + i) : 32'(8'h40 + i - 4));
        end
        w[0] = 1'b0; r[0] = 1'b0;
        din[0] = 8'h50; w[0] = 1'b1; step(); w[0] = 1'b0;
        chk("pre_rst_count", 32'(cnt[0]), 32'd5);

        // Asynchronous reset mid-stream.
        #3 rst = 1'b1;
        #1;
        chk("arst_count", 32'(cnt[0]), 32'd0);
        chk("arst_empty", 32'(empty[0]), 32'd1);
        chk("arst_full", 32'(full[0]), 32'd0);
        chk("arst_valid", 32'(vld[0]), 32'd0);
        chk("arst_ovf", 32'(ov[0]), 32'd0);
        step();
        rst = 1'b0;
        w[0] = 1'b1; din[0] = 8'h77; step(); w[0] = 1'b0;
        r[0] = 1'b1; step(); r[0] = 1'b0;
        chk("post_rst_data", 32'(dout[0]), 32'h77);
        chk("post_rst_valid", 32'(vld[0]), 32'd1);

        // FWFT instance.
        w[1] = 1'b1; din[1] = 8'hAB; step(); w[1] = 1'b0;
        chk("fwft_data", 32'(dout[1]), 32'hAB);
        chk("fwft_valid", 32'(vld[1]), 32'd1);
        r[1] = 1'b1; step(); r[1] = 1'b0;
        chk("fwft_pop_valid", 32'(vld[1]), 32'd0);
        chk("fwft_pop_empty", 32'(empty[1]), 32'd1);
        w[1] = 1'b1;
        din[1] = 8'h01; step();
        din[1] = 8'h02; step();
        w[1] = 1'b0;
        step();
        chk("fwft_head1", 32'(dout[1]), 32'h01);
        r[1] = 1'b1; step(); r[1] = 1'b0;
        chk("fwft_head2", 32'(dout[1]), 32'h02);
        r[1] = 1'b1; step(); r[1] = 1'b0;
        chk("fwft_final_empty", 32'(empty[1]), 32'd1);

        step(); step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sync_fifo_prog.md
Name: sync_fifo_prog

Overview:
Parametrised synchronous FIFO, next generation of the team's single-clock FIFO.
- Adds an exact occupancy count and runtime-programmable almost-full/almost-empty thresholds.
- Adds a selectable first-word-fall-through (FWFT) or standard read mode, plus sticky overflow/underflow error flags.
- Sits between producer/consumer datapath stages in the same clock domain.

Parameters:
DATA_WIDTH, 32, width of each stored word
DEPTH, 256, number of entries; power of two, >= 4
FWFT, 0, 0 = standard registered read, 1 = first-word-fall-through
AW (localparam), $clog2(DEPTH), pointer width; count/threshold width is AW+1

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
wr_en  in  1  write request
data_in  in  DATA_WIDTH  write data
rd_en  in  1  read (pop) request
af_thresh  in  AW+1  almost_full threshold, 0..DEPTH
ae_thresh  in  AW+1  almost_empty threshold, 0..DEPTH
clr_err  in  1  clears sticky overflow/underflow
data_out  out  DATA_WIDTH  read data
valid  out  1  data_out holds a valid popped/head word
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= af_thresh
almost_empty  out  1  count <= ae_thresh
count  out  AW+1  current occupancy 0..DEPTH
overflow  out  1  sticky: write attempted while full
underflow  out  1  sticky: read attempted while empty

Behaviour:
- Reset (rst high, asynchronous):
  - wr_ptr, rd_ptr and count go to 0; data_out = 0; valid = 0 in standard mode; overflow = underflow = 0.
  - Memory contents are not cleared.
  - Reset mid-operation discards all content; empty = 1 and full = 0 immediately.
- Write accept: wr_acc = wr_en && !full. mem[wr_ptr] <= data_in; wr_ptr increments and wraps modulo DEPTH.
- Read accept: rd_acc = rd_en && !empty. rd_ptr increments and wraps modulo DEPTH.
- Count, updated each edge:
  - +1 if wr_acc && !rd_acc.
  - -1 if rd_acc && !wr_acc.
  - Unchanged if both or neither.
  - Never exceeds DEPTH and never goes below 0.
- Simultaneous wr_en and rd_en:
  - Full: read accepted, write rejected (overflow sets), count becomes DEPTH-1.
  - Empty: write accepted, read rejected (underflow sets), count becomes 1.
  - Otherwise both are accepted and count is unchanged.
- Status flags:
  - full, empty, almost_full and almost_empty are combinational from the registered count and the threshold inputs, so they reflect state after the most recent edge. No extra cycle of lag.
  - Threshold inputs may change at any time; flags follow combinationally.
- Standard mode (FWFT=0):
  - On rd_acc, data_out <= mem[rd_ptr] at that edge; valid = 1 for exactly the following cycle.
  - data_out holds its last value otherwise; read latency is 1 cycle.
- FWFT mode (FWFT=1):
  - data_out = mem[rd_ptr] combinationally; valid = !empty.
  - A word written at edge N is visible on data_out after edge N (count = 1).
  - rd_en acts as an acknowledge/pop of the displayed word.
- Error flags:
  - overflow sets at the edge where wr_en && full; underflow sets at the edge where rd_en && empty.
  - Both clear on clr_err; a set condition in the same cycle as clr_err wins (flag stays 1).
  - Errors never alter pointers or count.
- Pointer wrap: after DEPTH writes and DEPTH reads, pointers return to 0 with no data corruption.

Test Plan:
- DEPTH=8, FWFT=0: write 8 words 0x10..0x17 -> count 8, full=1 after 8th edge; 9th write sets overflow=1, count stays 8; read 8 -> data_out 0x10..0x17, each with valid 1 cycle after its rd_en; empty=1.
- Empty FIFO, rd_en pulse -> underflow=1, count 0, valid stays 0; clr_err -> underflow=0; clr_err concurrent with rd_en while empty -> underflow stays 1.
- af_thresh=6, ae_thresh=2: fill one word at a time -> almost_empty=1 for count 0..2 and 0 at 3; almost_full=0 at count 5 and 1 at 6; change af_thresh to 7 at count 6 -> almost_full drops the same cycle.
- Full (count 8): wr_en and rd_en together -> oldest word read, write rejected, overflow=1, count 7. At count 4: both asserted for 20 cycles -> count stays 4, output order preserved across pointer wrap.
- FWFT=1: write 0xAB at edge N -> data_out=0xAB, valid=1 after edge N; rd_en -> valid=0, empty=1. Write 0x01 then 0x02 -> data_out=0x01 until popped, then 0x02.
- Assert rst at count 5 mid-stream -> count=0, empty=1, valid=0, errors=0 immediately; next write/read returns the new data, not stale data.
